// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter: arbitrates NREQ requesters onto one sequenced VRAM bus
// Ports: clk_i/reset_i (sync, active-high); req_i/we_i/addr_i/wdata_i packed per requester;
//        lock_mask_i blocks grants; rr_mode_i selects round-robin; ext_mode_i releases the bus;
//        gnt_o/done_o per requester; rdata_o/rdata_valid_o read return;
//        ma_o/md_out_o/md_drive_o/md_in_i/mcs_o/moe_o/mwr_o VRAM pins; busy_o while not idle.
module vram_bus_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int NREQ       = 3,
    parameter int STROBE_CYC = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*DATA_W-1:0]   wdata_i,
    input  logic [NREQ-1:0]          lock_mask_i,
    input  logic                     rr_mode_i,
    input  logic                     ext_mode_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          done_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     rdata_valid_o,
    output logic [ADDR_W-1:0]        ma_o,
    output logic [DATA_W-1:0]        md_out_o,
    output logic                     md_drive_o,
    input  logic [DATA_W-1:0]        md_in_i,
    output logic                     mcs_o,
    output logic                     moe_o,
    output logic                     mwr_o,
    output logic                     busy_o
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = STROBE_CYC > 1 ? $clog2(STROBE_CYC) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     win_d;
    logic              any_d;
    logic [NREQ-1:0]   elig;
    logic [CW-1:0]     cnt_q;
    logic              wr_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q;
    logic [ADDR_W-1:0] ma_q;
    logic [DATA_W-1:0] md_out_q;
    logic              md_drive_q;
    logic              mcs_q;
    logic              moe_q;
    logic              mwr_q;
    int                j;
    // Scan starts at the RR pointer in round-robin mode, at index 0 in fixed mode.
    always_comb begin
        elig  = req_i & ~lock_mask_i;
        win_d = '0;
        any_d = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = rr_mode_i ? (int'(ptr_q) + k) % NREQ : k;
            if (!any_d && elig[j]) begin
                any_d = 1'b1;
                win_d = IW'(j);
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            gnt_q         <= '0;
            done_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            ma_q          <= '0;
            md_out_q      <= '0;
            md_drive_q    <= 1'b0;
            mcs_q         <= 1'b0;
            moe_q         <= 1'b0;
            mwr_q         <= 1'b0;
        end else begin
            done_q        <= '0;
            rdata_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ext_mode_i && any_d) begin
                        state_q    <= SETUP;
                        gnt_q      <= NREQ'(1) << win_d;
                        ma_q       <= addr_i[win_d*ADDR_W +: ADDR_W];
                        md_out_q   <= wdata_i[win_d*DATA_W +: DATA_W];
                        wr_q       <= we_i[win_d];
                        md_drive_q <= we_i[win_d];
                        if (rr_mode_i)
                            ptr_q <= (win_d == IW'(NREQ-1)) ? '0 : win_d + 1'b1;
                    end else if (ext_mode_i) begin
                        ma_q     <= '0;
                        md_out_q <= '0;
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= CW'(STROBE_CYC-1);
                    mcs_q   <= 1'b1;
                    moe_q   <= !wr_q;
                    mwr_q   <= wr_q;
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        state_q <= HOLD;
                        mcs_q   <= 1'b0;
                        moe_q   <= 1'b0;
                        mwr_q   <= 1'b0;
                        done_q  <= gnt_q;
                        if (!wr_q) begin
                            rdata_q       <= md_in_i;
                            rdata_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    gnt_q      <= '0;
                    md_drive_q <= 1'b0;
                    // Pins go quiet on the first idle cycle if the bus is handed out.
                    if (ext_mode_i) begin
                        ma_q     <= '0;
                        md_out_q <= '0;
                    end
                end
            endcase
        end
    end
    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign ma_o          = ma_q;
    assign md_out_o      = md_out_q;
    assign md_drive_o    = md_drive_q;
    assign mcs_o         = mcs_q;
    assign moe_o         = moe_q;
    assign mwr_o         = mwr_q;
    assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb_vram_bus_arbiter: directed and random checks of vram_bus_arbiter against a transaction-level model
module tb_vram_bus_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int N  = 3;
    localparam int S  = 2;
    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic rr, ext;
    logic [DW-1:0] md_in;
    logic [N-1:0] gnt, done;
    logic [DW-1:0] rdata, md_out;
    logic rdata_valid, md_drive, mcs, moe, mwr, busy;
    logic [AW-1:0] ma;
    int n_checks = 0;
    int n_err = 0;
    int age = 0;
    int own = 0;
    int ptr = 0;
    logic wr = 1'b0;
    logic [AW-1:0] e_ma = '0;
    logic [DW-1:0] e_md = '0;
    logic [DW-1:0] e_rd = '0;

    vram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NREQ(N), .STROBE_CYC(S)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .lock_mask_i(lock), .rr_mode_i(rr), .ext_mode_i(ext), .gnt_o(gnt), .done_o(done),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid), .ma_o(ma), .md_out_o(md_out),
        .md_drive_o(md_drive), .md_in_i(md_in), .mcs_o(mcs), .moe_o(moe), .mwr_o(mwr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fixed: lowest eligible index. Round-robin: first eligible at or after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] e, input logic rrm, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = rrm ? (p + k) % N : k;
            if (e[i]) return i;
        end
        return -1;
    endfunction

    // age counts cycles since grant: 1 = setup, 2..S+1 = strobe, S+2 = hold, 0 = idle.
    task automatic model_step();
        int w;
        if (reset) begin
            age = 0; ptr = 0; own = 0; wr = 1'b0;
            e_ma = '0; e_md = '0; e_rd = '0;
        end else if (age == 0) begin
            w = pick(req & ~lock, rr, ptr);
            if (!ext && w >= 0) begin
                own = w; wr = we[w];
                e_ma = addr[w*AW +: AW];
                e_md = wdata[w*DW +: DW];
                age = 1;
                if (rr) ptr = (w + 1) % N;
            end else if (ext) begin
                e_ma = '0; e_md = '0;
            end
        end else if (age == S + 2) begin
            age = 0;
            if (ext) begin
                e_ma = '0; e_md = '0;
            end
        end else begin
            if (age == S + 1 && !wr) e_rd = md_in;
            age++;
        end
    endtask

    always @(posedge clk) begin
        logic [N-1:0] eg;
        logic strobe;
        model_step();
        #1;
        eg = (age != 0) ? N'(1 << own) : '0;
        strobe = age >= 2 && age <= S + 1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("done", 64'(done), 64'((age == S + 2) ? eg : '0));
        chk("rdata_valid", 64'(rdata_valid), 64'(age == S + 2 && !wr));
        chk("rdata", 64'(rdata), 64'(e_rd));
        chk("ma", 64'(ma), 64'(e_ma));
        chk("md_out", 64'(md_out), 64'(e_md));
        chk("md_drive", 64'(md_drive), 64'(age != 0 && wr));
        chk("mcs", 64'(mcs), 64'(strobe));
        chk("moe", 64'(moe), 64'(strobe && !wr));
        chk("mwr", 64'(mwr), 64'(strobe && wr));
        chk("busy", 64'(busy), 64'(age != 0));
    end

    initial begin
        reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        rr = 1'b0; ext = 1'b0; md_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ma", 64'(ma), 64'h0);
        chk("rst_mcs", 64'(mcs), 64'h0);
        reset = 1'b0;
        // single read by requester 1
        addr[AW +: AW] = 13'h1ABC; md_in = 8'h5A; req = 3'b010;
        @(negedge clk);
        chk("rd_gnt", 64'(gnt), 64'h2);
        chk("rd_ma", 64'(ma), 64'h1ABC);
        chk("rd_setup_mcs", 64'(mcs), 64'h0);
        @(negedge clk);
        chk("rd_moe1", 64'(moe), 64'h1);
        @(negedge clk);
        chk("rd_moe2", 64'(moe), 64'h1);
        @(negedge clk);
        chk("rd_done", 64'(done), 64'h2);
        chk("rd_valid", 64'(rdata_valid), 64'h1);
        chk("rd_data", 64'(rdata), 64'h5A);
        chk("rd_hold_moe", 64'(moe), 64'h0);
        req = '0;
        @(negedge clk);
        chk("rd_idle", 64'(busy), 64'h0);
        // single write by requester 0
        addr[0 +: AW] = 13'h0010; wdata[0 +: DW] = 8'hC3; we = 3'b001; req = 3'b001;
        @(negedge clk);
        chk("wr_drive_setup", 64'(md_drive), 64'h1);
        chk("wr_md_out", 64'(md_out), 64'hC3);
        @(negedge clk);
        chk("wr_mwr1", 64'(mwr), 64'h1);
        chk("wr_no_moe", 64'(moe), 64'h0);
        @(negedge clk);
        chk("wr_mwr2", 64'(mwr), 64'h1);
        @(negedge clk);
        chk("wr_done", 64'(done), 64'h1);
        chk("wr_drive_hold", 64'(md_drive), 64'h1);
        req = '0; we = '0;
        @(negedge clk);
        chk("wr_drive_off", 64'(md_drive), 64'h0);
        // fixed priority starves 1 and 2, then round-robin from pointer 0
        req = 3'b111;
        @(negedge clk);
        chk("fx_gnt0", 64'(gnt), 64'h1);
        repeat (5) @(negedge clk);
        chk("fx_gnt1", 64'(gnt), 64'h1);
        repeat (5) @(negedge clk);
        chk("fx_gnt2", 64'(gnt), 64'h1);
        rr = 1'b1;
        repeat (5) @(negedge clk);
        chk("rr_gnt0", 64'(gnt), 64'h1);
        repeat (5) @(negedge clk);
        chk("rr_gnt1", 64'(gnt), 64'h2);
        repeat (5) @(negedge clk);
        chk("rr_gnt2", 64'(gnt), 64'h4);
        repeat (5) @(negedge clk);
        chk("rr_gnt3", 64'(gnt), 64'h1);
        req = '0; rr = 1'b0;
        repeat (5) @(negedge clk);
        // lockout, plus lock raised mid-strobe
        lock = 3'b001; req = 3'b011;
        @(negedge clk);
        chk("lk_gnt", 64'(gnt), 64'h2);
        @(negedge clk);
        lock = 3'b011;
        @(negedge clk);
        @(negedge clk);
        chk("lk_done", 64'(done), 64'h2);
        req = '0; lock = '0;
        @(negedge clk);
        // external mode
        ext = 1'b1; req = 3'b111;
        repeat (6) @(negedge clk);
        chk("ext_gnt", 64'(gnt), 64'h0);
        chk("ext_busy", 64'(busy), 64'h0);
        chk("ext_ma", 64'(ma), 64'h0);
        chk("ext_strobes", 64'({mcs, moe, mwr}), 64'h0);
        ext = 1'b0;
        @(negedge clk);
        chk("ext_off_gnt", 64'(gnt), 64'h1);
        @(negedge clk);
        ext = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ext_mid_done", 64'(done), 64'h1);
        @(negedge clk);
        chk("ext_after_busy", 64'(busy), 64'h0);
        chk("ext_after_ma", 64'(ma), 64'h0);
        @(negedge clk);
        chk("ext_stay_idle", 64'(gnt), 64'h0);
        ext = 1'b0; req = '0;
        @(negedge clk);
        // reset during a read strobe
        addr[2*AW +: AW] = 13'h0F0F; req = 3'b100;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_gnt", 64'(gnt), 64'h0);
        chk("mr_done", 64'(done), 64'h0);
        chk("mr_valid", 64'(rdata_valid), 64'h0);
        chk("mr_rdata", 64'(rdata), 64'h0);
        chk("mr_busy", 64'(busy), 64'h0);
        chk("mr_pins", 64'({ma, mcs, moe, mwr, md_drive}), 64'h0);
        reset = 1'b0; req = '0;
        // random traffic
        repeat (4000) begin
            @(negedge clk);
            reset = $urandom_range(0, 299) == 0;
            ext   = $urandom_range(0, 11) == 0;
            rr    = $urandom_range(0, 1) == 1;
            req   = N'($urandom);
            we    = N'($urandom);
            lock  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            addr  = (N*AW)'({$urandom(), $urandom()});
            wdata = (N*DW)'($urandom);
            md_in = DW'($urandom);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
